// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and default widths for the APB master
package apb_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} apb_state_t;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS wait cycles and flags when TIMEOUT is reached
module apb_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge pclk) begin
        if (prst || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 8'd1;
    end
    assign expired = cnt == 8'(TIMEOUT);
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding command to APB bridge with wait timeout
module apb_master import apb_pkg::*; #(
    parameter int addrWidth  = APB_ADDR_W,
    parameter int dataWidth  = APB_DATA_W,
    parameter int TIMEOUT    = 15,
    parameter int RDATA_LATE = 1
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 pen,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);
    localparam bit LATE = RDATA_LATE != 0;

    apb_state_t state, nxt;
    logic accept, done, expired, psel_d, pen_d, rsp_valid_d;

    assign cmd_ready = state == IDLE && !prst;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = state == ACCESS && nxt != ACCESS;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .pclk   (pclk),
        .prst   (prst),
        .clear  (state == SETUP),
        .enable (state == ACCESS && !pready),
        .expired(expired)
    );

    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            pen       <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= nxt;
            psel      <= psel_d;
            pen       <= pen_d;
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
            // early capture only for reads when the late-data path is disabled
            if (done) begin
                rsp_err   <= !pready;
                rsp_rdata <= (pready && !pwrite && !LATE) ? prdata : '0;
            end
            if (state == CAPTURE) rsp_rdata <= prdata;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? SETUP : IDLE;
            SETUP:   nxt = ACCESS;
            ACCESS:  nxt = pready ? ((!pwrite && LATE) ? CAPTURE : RESP) : (expired ? RESP : ACCESS);
            CAPTURE: nxt = RESP;
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        psel_d      = nxt == SETUP || nxt == ACCESS;
        pen_d       = nxt == ACCESS;
        rsp_valid_d = nxt == RESP;
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of the APB master against a late-data slave model
module tb_apb_master;
    logic       pclk = 1'b0;
    logic       prst, cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata, paddr, pwdata;
    logic       pwrite, psel, pen, pready;
    logic [7:0] prdata = 8'h01;
    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_master dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .pen(pen), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    // slave presents read data one cycle after completion, 0x01 otherwise
    always @(posedge pclk) begin
        if (psel && pen && pready && pwrite) mem[paddr] <= pwdata;
        prdata <= (psel && pen && pready && !pwrite) ? mem[paddr] : 8'h01;
    end

    task automatic step();
        @(posedge pclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b1;
        repeat (2) step();
        chk("rst_psel", {7'b0, psel}, 8'h00);
        chk("rst_pen", {7'b0, pen}, 8'h00);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'h00);
        chk("rst_paddr", paddr, 8'h00);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        prst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", {7'b0, cmd_ready}, 8'h01);

        issue(1'b1, 8'h10, 8'hA5);
        chk("wr_setup_psel", {7'b0, psel}, 8'h01);
        chk("wr_setup_pen", {7'b0, pen}, 8'h00);
        chk("wr_paddr", paddr, 8'h10);
        chk("wr_pwdata", pwdata, 8'hA5);
        chk("wr_pwrite", {7'b0, pwrite}, 8'h01);
        chk("wr_busy_cmd_ready", {7'b0, cmd_ready}, 8'h00);
        step();
        chk("wr_access_psel", {7'b0, psel}, 8'h01);
        chk("wr_access_pen", {7'b0, pen}, 8'h01);
        chk("wr_access_paddr", paddr, 8'h10);
        chk("wr_access_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        step();
        chk("wr_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("wr_rsp_err", {7'b0, rsp_err}, 8'h00);
        chk("wr_rsp_rdata", rsp_rdata, 8'h00);
        chk("wr_resp_psel", {7'b0, psel}, 8'h00);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_done_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("wr_done_cmd_ready", {7'b0, cmd_ready}, 8'h01);

        issue(1'b0, 8'h10, 8'h77);
        chk("rd_pwdata_zero", pwdata, 8'h00);
        chk("rd_pwrite", {7'b0, pwrite}, 8'h00);
        step();
        chk("rd_access_pen", {7'b0, pen}, 8'h01);
        step();
        chk("rd_capture_psel", {7'b0, psel}, 8'h00);
        chk("rd_capture_pen", {7'b0, pen}, 8'h00);
        chk("rd_capture_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        step();
        chk("rd_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
        chk("rd_rsp_err", {7'b0, rsp_err}, 8'h00);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", {7'b0, rsp_valid}, 8'h01);
            chk("hold_rsp_rdata", rsp_rdata, 8'hA5);
            chk("hold_cmd_ready", {7'b0, cmd_ready}, 8'h00);
            chk("hold_psel", {7'b0, psel}, 8'h00);
            step();
        end
        rsp_ready = 1'b1;
        chk("hold_release_cmd_ready", {7'b0, cmd_ready}, 8'h00);
        step();
        rsp_ready = 1'b0;
        chk("after_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("after_rsp_psel", {7'b0, psel}, 8'h00);
        chk("after_rsp_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        step();
        cmd_valid = 1'b0;
        chk("second_cmd_psel", {7'b0, psel}, 8'h01);
        chk("second_cmd_paddr", paddr, 8'h20);
        repeat (2) step();
        chk("second_cmd_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        pready = 1'b0;
        issue(1'b0, 8'h10, 8'h00);
        step();
        repeat (15) step();
        chk("wait15_psel", {7'b0, psel}, 8'h01);
        chk("wait15_pen", {7'b0, pen}, 8'h01);
        chk("wait15_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        pready = 1'b1;
        step();
        chk("wait15_capture_psel", {7'b0, psel}, 8'h00);
        step();
        chk("wait15_rsp_valid_done", {7'b0, rsp_valid}, 8'h01);
        chk("wait15_rsp_err", {7'b0, rsp_err}, 8'h00);
        chk("wait15_rsp_rdata", rsp_rdata, 8'hA5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        pready = 1'b0;
        issue(1'b0, 8'h10, 8'h00);
        step();
        repeat (15) step();
        chk("wait16_still_access", {7'b0, pen}, 8'h01);
        step();
        chk("timeout_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("timeout_rsp_err", {7'b0, rsp_err}, 8'h01);
        chk("timeout_rsp_rdata", rsp_rdata, 8'h00);
        chk("timeout_psel", {7'b0, psel}, 8'h00);
        chk("timeout_pen", {7'b0, pen}, 8'h00);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        pready = 1'b1;

        pready = 1'b0;
        issue(1'b0, 8'h10, 8'h00);
        step();
        step();
        chk("pre_rst_psel", {7'b0, psel}, 8'h01);
        chk("pre_rst_pen", {7'b0, pen}, 8'h01);
        prst = 1'b1;
        step();
        chk("mid_rst_psel", {7'b0, psel}, 8'h00);
        chk("mid_rst_pen", {7'b0, pen}, 8'h00);
        chk("mid_rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("mid_rst_cmd_ready", {7'b0, cmd_ready}, 8'h00);
        prst = 1'b0;
        pready = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        repeat (3) step();
        chk("post_rst_no_rsp", {7'b0, rsp_valid}, 8'h00);
        chk("post_rst_idle_psel", {7'b0, psel}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
